// File: rtl/cpu_fetch_stage.sv
// RV32 instruction fetch: owns the PC, issues 1-cycle-latency imem reads, buffers them for decode.
// Latency: request at N, out_valid at N+2 (N+1 with CPU_FETCH_BYPASS_EN); stalls on !out_ready via FIFO credits.
module cpu_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus_4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef logic [AW-1:0] ptr_t;

    logic [31:0]   r_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic [CW-1:0] r_count;
    ptr_t          r_rd_ptr;
    ptr_t          r_wr_ptr;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];

    logic [CW:0]   w_occ;
    logic          w_issue;
    logic          w_resp;
    logic          w_fifo_vld;
    logic          w_byp;
    logic          w_push;
    logic          w_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Credits count the read in flight so a returning word always has a slot.
    assign w_occ      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue    = rst_n && !redirect && (w_occ < DEPTH_W);
    assign w_resp     = r_inflight && !redirect;
    assign w_fifo_vld = (r_count != '0);

`ifdef CPU_FETCH_BYPASS_EN
    assign w_byp = w_resp && !w_fifo_vld;
`else
    assign w_byp = 1'b0;
`endif

    assign w_pop  = w_fifo_vld && out_ready && !redirect;
    assign w_push = w_resp && !(w_byp && out_ready);

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    // Outputs are forced to zero when nothing is valid so reset clears them immediately.
    assign out_valid       = w_fifo_vld || w_byp;
    assign out_instruction = w_byp ? imem_rdata :
                             (w_fifo_vld ? r_mem_instr[r_rd_ptr] : 32'h0);
    assign out_pc          = w_byp ? r_inflight_pc :
                             (w_fifo_vld ? r_mem_pc[r_rd_ptr] : 32'h0);
    assign out_pc_plus_4   = out_valid ? (out_pc + 32'd4) : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= PC_INIT;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
        end else begin
            r_inflight <= w_issue;
            if (redirect) begin
                r_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (w_issue) begin
                r_pc          <= r_pc + 32'd4;
                r_inflight_pc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end
endmodule

// File: tb/tb_cpu_fetch_stage.sv
// Directed bench for cpu_fetch_stage; memory returns addr ^ 32'hA5A5_0000 one cycle after a request.
module tb_cpu_fetch_stage;
    localparam logic [31:0] XK = 32'hA5A5_0000;
`ifdef CPU_FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;

    int tests = 0;
    int fails = 0;

    cpu_fetch_stage #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_req) imem_rdata <= imem_addr ^ XK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at posedge+1 with the next accepted output, or ok=0 after 20 cycles.
    task automatic wait_accept(output logic ok, output logic [31:0] pc, output logic [31:0] ins,
                               output logic [31:0] p4);
        ok = 1'b0; pc = 32'h0; ins = 32'h0; p4 = 32'h0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                ok = 1'b1; pc = out_pc; ins = out_instruction; p4 = out_pc_plus_4;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input logic ready);
        rst_n = 1'b0; redirect = 1'b0; out_ready = ready;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic expect_seq(input string name, input logic [31:0] first, input int n);
        logic ok; logic [31:0] pc, ins, p4;
        for (int k = 0; k < n; k++) begin
            wait_accept(ok, pc, ins, p4);
            tests++;
            if (!ok || pc !== first + 32'(4 * k) || ins !== ((first + 32'(4 * k)) ^ XK) ||
                p4 !== first + 32'(4 * k) + 32'd4) begin
                fails++;
                $display("FAIL %s[%0d]: got ok=%0b pc=%h ins=%h p4=%h, want pc=%h", name, k, ok,
                         pc, ins, p4, first + 32'(4 * k));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || out_pc !== 32'h0 ||
            out_instruction !== 32'h0 || out_pc_plus_4 !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: valid=%b req=%b pc=%h ins=%h p4=%h, want all 0",
                     out_valid, imem_req, out_pc, out_instruction, out_pc_plus_4);
        end
    endtask

    task automatic test_stream();
        int c;
        logic [31:0] pc;
        do_reset(1'b1);
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            fails++;
            $display("FAIL first_req: req=%b addr=%h, want 1 00000100", imem_req, imem_addr);
        end
        c = 0; pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            if (out_valid) begin c = i; pc = out_pc; break; end
            c = 99;
            @(posedge clk); #1;
        end
        tests++;
        if (c !== LAT || pc !== 32'h100) begin
            fails++;
            $display("FAIL first_valid: cycle=%0d pc=%h, want cycle=%0d pc=00000100", c, pc, LAT);
        end
        @(posedge clk); #1;
        expect_seq("stream", 32'h104, 2);
    endtask

    task automatic test_stall();
        int c;
        do_reset(1'b0);
        c = 99;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin c = i; break; end
            @(posedge clk); #1;
        end
        tests++;
        if (c !== LAT) begin
            fails++;
            $display("FAIL stall_first_valid: cycle=%0d want %0d", c, LAT);
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 || (k >= 1 && imem_req !== 1'b0)) begin
                fails++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h req=%b, want 1 00000100 req0",
                         k, out_valid, out_pc, imem_req);
            end
            @(posedge clk); #1;
            if (k < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        expect_seq("stall_release", 32'h100, 3);
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0);
        repeat (5) @(posedge clk);
        #1 redirect = 1'b1; redirect_pc = 32'h2003;
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL redir_req_low: req=%b want 0", imem_req);
        end
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
            fails++;
            $display("FAIL redir_next: valid=%b req=%b addr=%h, want 0 1 00002000",
                     out_valid, imem_req, imem_addr);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        expect_seq("redir_target", 32'h2000, 2);
    endtask

    task automatic test_redirect_resp();
        logic hit;
        do_reset(1'b1);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            hit = imem_req && (imem_addr == 32'h108);
            @(posedge clk); #1;
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL redir_resp_find: request for 00000108 not seen");
        end
        redirect = 1'b1; redirect_pc = 32'h3000;
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_resp_drop: valid=%b pc=%h, want valid 0", out_valid, out_pc);
        end
        @(posedge clk); #1;
        expect_seq("redir_resp_target", 32'h3000, 1);
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 32'h4000;
        @(posedge clk); #1 redirect_pc = 32'h5000;
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL b2b_req_low: req=%b want 0", imem_req);
        end
        @(posedge clk); #1 redirect = 1'b0;
        expect_seq("b2b_last_wins", 32'h5000, 1);
    endtask

    task automatic test_wrap();
        logic ok; logic [31:0] pc, ins, p4;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1 redirect = 1'b0;
        wait_accept(ok, pc, ins, p4);
        tests++;
        if (!ok || pc !== 32'hFFFF_FFFC || ins !== 32'h5A5A_FFFC || p4 !== 32'h0) begin
            fails++;
            $display("FAIL wrap_top: ok=%b pc=%h ins=%h p4=%h, want fffffffc 5a5afffc 00000000",
                     ok, pc, ins, p4);
        end
        wait_accept(ok, pc, ins, p4);
        tests++;
        if (!ok || pc !== 32'h0 || ins !== 32'hA5A5_0000 || p4 !== 32'h4) begin
            fails++;
            $display("FAIL wrap_zero: ok=%b pc=%h ins=%h p4=%h, want 00000000 a5a50000 00000004",
                     ok, pc, ins, p4);
        end
    endtask

    task automatic test_async_reset();
        logic hit;
        int c;
        logic [31:0] pc;
        out_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            hit = imem_req && out_valid;
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (!hit || out_valid !== 1'b0 || imem_req !== 1'b0 || out_pc !== 32'h0 ||
            out_instruction !== 32'h0 || out_pc_plus_4 !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: hit=%b valid=%b req=%b pc=%h ins=%h p4=%h, want zeros",
                     hit, out_valid, imem_req, out_pc, out_instruction, out_pc_plus_4);
        end
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        c = 99; pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin c = i; pc = out_pc; break; end
            @(posedge clk); #1;
        end
        tests++;
        if (c !== LAT || pc !== 32'h100) begin
            fails++;
            $display("FAIL async_restart: cycle=%0d pc=%h, want cycle=%0d pc=00000100", c, pc, LAT);
        end
        @(posedge clk); #1;
        expect_seq("async_after", 32'h104, 1);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_resp();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
